// File: rtl/ifetch_queue.sv
// ifetch_queue: fetches FETCH_WIDTH-word blocks into a circular queue
// and hands decode one instruction per cycle (valid/deq handshake).
// Ports: clock/reset (sync, active-high); cache_* block read port;
//   load_pc/new_pc redirect; inst_* queue head; deq consume;
//   queue_count occupancy.
// Option: define IFETCH_BYPASS_EN to forward a block straight to
//   inst_* when the queue is empty (1-cycle redirect latency).
module ifetch_queue #(
  parameter int ADDR_WIDTH  = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int QUEUE_DEPTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic [ADDR_WIDTH-1:0]       cache_addr,
  output logic                        cache_rd,
  input  logic [32*FETCH_WIDTH-1:0]   cache_data,
  input  logic                        cache_waitrequest,
  input  logic                        load_pc,
  input  logic [ADDR_WIDTH-1:0]       new_pc,
  output logic                        inst_valid,
  output logic [31:0]                 inst_word,
  output logic [ADDR_WIDTH-1:0]       inst_pc,
  input  logic                        deq,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count
);

  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int CW = QW + 1;
  localparam int LW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int BW = $clog2(FETCH_WIDTH * 4);

  typedef enum logic {RUN, STALE} state_t;

  state_t r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_stale_addr;
  logic [CW-1:0] r_wp, r_rp;
  logic          r_go;
  logic [31:0]           r_q_word [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] r_q_pc   [QUEUE_DEPTH];

  logic [ADDR_WIDTH-1:0] w_blk;
  logic [LW-1:0] w_off;
  logic [LW:0]   w_need, w_first;
  logic [CW-1:0] w_count, w_free, w_nenq;
  logic          w_empty, w_deq, w_acc, w_enq_ok;
  logic          w_byp, w_skip;
  logic [31:0]   w_lane [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] w_we;
  logic [QW-1:0] w_widx [FETCH_WIDTH];

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
    assign w_lane[g] = cache_data[32*g +: 32];
  end

  if (FETCH_WIDTH > 1) begin : g_off
    assign w_off = r_fetch_pc[BW-1:2];
  end else begin : g_off0
    assign w_off = '0;
  end

  assign w_blk   = r_fetch_pc & ~ADDR_WIDTH'(FETCH_WIDTH*4 - 1);
  assign w_count = r_wp - r_rp;
  assign w_empty = (w_count == '0);
  assign w_deq   = deq & ~w_empty;
  // a dequeue this cycle already frees a slot for the next block
  assign w_free  = CW'(QUEUE_DEPTH) - w_count + CW'(w_deq);
  assign w_need  = (LW+1)'(FETCH_WIDTH) - {1'b0, w_off};

  // r_go keeps the read port quiet for the first cycle after reset
  assign cache_rd = r_go &
                    ((r_state == STALE) | (w_free >= CW'(w_need)));
  assign cache_addr = (r_state == STALE) ? r_stale_addr : w_blk;

  assign w_acc    = cache_rd & ~cache_waitrequest;
  assign w_enq_ok = w_acc & (r_state == RUN) & ~load_pc;

`ifdef IFETCH_BYPASS_EN
  assign w_byp = w_enq_ok & w_empty;
`else
  assign w_byp = 1'b0;
`endif

  // a bypassed lane consumed this cycle never enters the queue
  assign w_skip  = w_byp & deq;
  assign w_first = {1'b0, w_off} + (LW+1)'(w_skip);
  assign w_nenq  = w_enq_ok ?
                   CW'((LW+1)'(FETCH_WIDTH) - w_first) : '0;

  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_we[i]   = w_enq_ok && (i >= int'(w_first));
      w_widx[i] = r_wp[QW-1:0] + QW'(i - int'(w_first));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN: begin
        if (load_pc & cache_rd & cache_waitrequest)
          w_state_nxt = STALE;
      end
      STALE: begin
        if (~cache_waitrequest)
          w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= RUN;
      r_fetch_pc   <= RESET_PC;
      r_stale_addr <= '0;
      r_wp         <= '0;
      r_rp         <= '0;
      r_go         <= 1'b0;
    end else begin
      r_go    <= 1'b1;
      r_state <= w_state_nxt;
      if (load_pc) begin
        r_wp       <= '0;
        r_rp       <= '0;
        r_fetch_pc <= new_pc;
        if ((r_state == RUN) & cache_rd & cache_waitrequest)
          r_stale_addr <= cache_addr;
      end else begin
        r_rp <= r_rp + CW'(w_deq);
        r_wp <= r_wp + w_nenq;
        if (w_acc & (r_state == RUN))
          r_fetch_pc <= w_blk + ADDR_WIDTH'(FETCH_WIDTH*4);
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (w_we[i]) begin
        r_q_word[w_widx[i]] <= w_lane[i];
        r_q_pc[w_widx[i]]   <= w_blk + ADDR_WIDTH'(4*i);
      end
    end
  end

  assign inst_valid  = ~w_empty | w_byp;
  assign queue_count = w_count;

  always_comb begin
    inst_word = '0;
    inst_pc   = '0;
    if (~w_empty) begin
      inst_word = r_q_word[r_rp[QW-1:0]];
      inst_pc   = r_q_pc[r_rp[QW-1:0]];
    end else if (w_byp) begin
      inst_word = w_lane[w_off];
      inst_pc   = r_fetch_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: random stimulus against an instruction-stream
// model; expected instructions are scoreboarded for a monitor.
module tb_ifetch_queue;

  localparam int AW = 32;
  localparam int FW = 2;
  localparam int QD = 8;
  localparam logic [31:0] RPC = 32'h0;
`ifdef IFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic [AW-1:0] cache_addr;
  logic cache_rd;
  logic [32*FW-1:0] cache_data;
  logic cache_waitrequest;
  logic load_pc;
  logic [AW-1:0] new_pc;
  logic inst_valid;
  logic [31:0] inst_word;
  logic [AW-1:0] inst_pc;
  logic deq;
  logic [$clog2(QD):0] queue_count;

  ifetch_queue #(
    .ADDR_WIDTH(AW), .FETCH_WIDTH(FW),
    .QUEUE_DEPTH(QD), .RESET_PC(RPC)
  ) dut (
    .clock(clock), .reset(reset),
    .cache_addr(cache_addr), .cache_rd(cache_rd),
    .cache_data(cache_data),
    .cache_waitrequest(cache_waitrequest),
    .load_pc(load_pc), .new_pc(new_pc),
    .inst_valid(inst_valid), .inst_word(inst_word),
    .inst_pc(inst_pc), .deq(deq),
    .queue_count(queue_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  always_comb begin
    cache_data = '0;
    for (int i = 0; i < FW; i++)
      cache_data[32*i +: 32] = memword(cache_addr + 32'(4*i));
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // reference model: fetch PC, stale-request flag and the
  // expected instruction stream (PCs in program order)
  logic [31:0] scb [$];
  logic [31:0] m_pc;
  logic [31:0] m_stale_addr;
  bit m_stale, m_go, m_init = 1'b0;

  always @(posedge clock) begin : mdl
    int cnt, off, free, need;
    logic [31:0] blk, eaddr;
    bit erd, acc, byp, evalid;
    #2;
    if (m_init) begin
      cnt   = scb.size();
      blk   = m_pc - (m_pc % (FW*4));
      off   = int'((m_pc % (FW*4)) / 4);
      free  = QD - cnt + ((deq && cnt > 0) ? 1 : 0);
      need  = FW - off;
      erd   = m_go && (m_stale || free >= need);
      eaddr = m_stale ? m_stale_addr : blk;
      acc   = erd && !cache_waitrequest;
      byp   = BYP && acc && !m_stale && !load_pc && cnt == 0;
      evalid = (cnt > 0) || byp;
      chk("cache_rd", 64'(cache_rd), 64'(erd));
      chk("cache_addr", 64'(cache_addr), 64'(eaddr));
      chk("queue_count", 64'(queue_count), 64'(cnt));
      chk("inst_valid", 64'(inst_valid), 64'(evalid));
      if (!m_go) begin
        chk("rst_inst_word", 64'(inst_word), 64'h0);
        chk("rst_inst_pc", 64'(inst_pc), 64'h0);
      end
      if (!reset) begin
        if (load_pc) begin
          if (erd && cache_waitrequest && !m_stale)
            m_stale_addr = eaddr;
          m_stale = erd && cache_waitrequest;
          m_pc = new_pc;
          scb.delete();
        end else if (m_stale) begin
          if (!cache_waitrequest) m_stale = 1'b0;
        end else if (acc) begin
          for (int i = off; i < FW; i++)
            scb.push_back(blk + 32'(4*i));
          m_pc = blk + 32'(FW*4);
        end
        m_go = 1'b1;
      end
    end
    if (reset) begin
      scb.delete();
      m_pc = RPC;
      m_stale = 1'b0;
      m_stale_addr = '0;
      m_go = 1'b0;
      m_init = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (m_init && !reset && inst_valid && !load_pc) begin
      if (scb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL head: got valid pc %0h expected empty queue",
                 inst_pc);
      end else begin
        chk("inst_pc", 64'(inst_pc), 64'(scb[0]));
        chk("inst_word", 64'(inst_word), 64'(memword(scb[0])));
        if (deq) void'(scb.pop_front());
      end
    end
  end

  task automatic drive(input bit w, input bit d,
                       input bit l, input logic [31:0] p);
    @(posedge clock);
    #1;
    cache_waitrequest = w;
    deq = d;
    load_pc = l;
    new_pc = p;
  endtask

  function automatic logic [31:0] pick_pc();
    logic [31:0] pcs [5];
    pcs[0] = 32'h104;
    pcs[1] = 32'h200;
    pcs[2] = 32'hFFFF_FFFC;
    pcs[3] = 32'hFFFF_FFF0;
    pcs[4] = $urandom & 32'hFFFF_FFFC;
    return pcs[$urandom_range(0, 4)];
  endfunction

  initial begin
    reset = 1'b1;
    cache_waitrequest = 1'b0;
    deq = 1'b0;
    load_pc = 1'b0;
    new_pc = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (30) drive(0, 1, 0, 0);
    repeat (12) drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    repeat (4) drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    repeat (4) drive(0, 0, 0, 0);
    drive(0, 1, 1, 32'h104);
    repeat (6) drive(0, 1, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 1, 1, 32'h200);
    drive(1, 1, 0, 0);
    repeat (6) drive(0, 1, 0, 0);
    drive(0, 1, 1, 32'h400);
    repeat (4) drive(0, 1, 0, 0);
    drive(0, 1, 1, 32'hFFFF_FFF8);
    repeat (6) drive(0, 1, 0, 0);
    for (int c = 0; c < 1500; c++)
      drive($urandom_range(0, 3) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0,
            pick_pc());
    drive(0, 0, 1, 32'h300);
    repeat (2) drive(0, 0, 0, 0);
    repeat (2) drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    reset = 1'b1;
    drive(1, 1, 0, 0);
    reset = 1'b0;
    repeat (10) drive(0, 1, 0, 0);
    for (int c = 0; c < 300; c++)
      drive($urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 0,
            $urandom_range(0, 11) == 0,
            pick_pc());
    drive(0, 0, 0, 0);
    @(posedge clock);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
